// File: rtl/fs_ds_skid_reg.sv
// IF->ID pipeline register built as a two-entry skid buffer with a registered
// upstream ready, so decode stalls never reach the fetch logic combinationally.
module fs_ds_skid_reg #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fs_to_ds_reg_valid,
    input  logic [DATA_W-1:0] fs_data,
    output logic              fs_ds_reg_allow_in,
    input  logic              ds_allow_in,
    output logic              ds_valid,
    output logic [DATA_W-1:0] ds_data,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    logic [DATA_W-1:0] slot_r [2];
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        count_r;
    logic              allow_in_r;

    logic              push_s;
    logic              pop_s;
    logic [1:0]        count_next_s;

    // Handshake qualification; flush overrides both sides of the transfer.
    always_comb begin
        push_s = fs_to_ds_reg_valid & allow_in_r & ~flush;
        pop_s  = (count_r != 2'd0) & ds_allow_in & ~flush;
    end

    // Next occupancy; a flush empties the buffer regardless of traffic.
    always_comb begin
        count_next_s = count_r;
        if (flush) begin
            count_next_s = 2'd0;
        end else begin
            count_next_s = count_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // Pointer, occupancy and upstream-ready registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
            count_r    <= 2'd0;
            allow_in_r <= 1'b1;
        end else if (flush) begin
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
            count_r    <= 2'd0;
            allow_in_r <= 1'b1;
        end else begin
            wr_ptr_r   <= wr_ptr_r ^ push_s;
            rd_ptr_r   <= rd_ptr_r ^ pop_s;
            count_r    <= count_next_s;
            // Ready looks at the post-update fill level, not at ds_allow_in.
            allow_in_r <= (count_next_s != 2'd2);
        end
    end

    // Payload storage; a slot is written only when the push targets it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_r[0] <= {DATA_W{1'b0}};
            slot_r[1] <= {DATA_W{1'b0}};
        end else if (push_s) begin
            slot_r[wr_ptr_r] <= fs_data;
        end else begin
            slot_r[0] <= slot_r[0];
            slot_r[1] <= slot_r[1];
        end
    end

    // Downstream view is decoded from flops only.
    always_comb begin
        fs_ds_reg_allow_in = allow_in_r;
        ds_valid           = (count_r != 2'd0);
        ds_data            = slot_r[rd_ptr_r];
        occupancy          = count_r;
    end

endmodule

// File: tb/tb_fs_ds_skid_reg.sv
// Self-checking bench for fs_ds_skid_reg: directed scenarios plus random traffic
// compared every cycle against a FIFO-queue model of the buffer.
module tb_fs_ds_skid_reg;

    logic        clk;
    logic        reset;
    logic        fs_to_ds_reg_valid;
    logic [63:0] fs_data;
    logic        fs_ds_reg_allow_in;
    logic        ds_allow_in;
    logic        ds_valid;
    logic [63:0] ds_data;
    logic        flush;
    logic [1:0]  occupancy;

    int tests_run = 0;
    int tests_failed = 0;

    logic [63:0] q[$];
    bit          m_allow = 1'b1;

    fs_ds_skid_reg #(.DATA_W(64)) dut (
        .clk                (clk),
        .reset              (reset),
        .fs_to_ds_reg_valid (fs_to_ds_reg_valid),
        .fs_data            (fs_data),
        .fs_ds_reg_allow_in (fs_ds_reg_allow_in),
        .ds_allow_in        (ds_allow_in),
        .ds_valid           (ds_valid),
        .ds_data            (ds_data),
        .flush              (flush),
        .occupancy          (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        chk("ds_valid", {63'd0, ds_valid}, {63'd0, (q.size() != 0)});
        chk("occupancy", {62'd0, occupancy}, 64'(q.size()));
        chk("allow_in", {63'd0, fs_ds_reg_allow_in}, {63'd0, m_allow});
        if (q.size() != 0) chk("ds_data", ds_data, q[0]);
    endtask

    function automatic logic [63:0] mk(input logic [31:0] pc);
        return {32'h0000_0013, pc};
    endfunction

    // Drive one cycle of inputs at a falling edge, advance the model, then check.
    task automatic step(input logic v, input logic [63:0] d, input logic a, input logic f);
        bit push;
        bit pop;
        fs_to_ds_reg_valid = v;
        fs_data            = d;
        ds_allow_in        = a;
        flush              = f;
        push = v && m_allow && !f;
        pop  = (q.size() != 0) && a && !f;
        if (f) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(d);
        end
        m_allow = (q.size() != 2);
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    initial begin
        reset = 1'b0;
        fs_to_ds_reg_valid = 1'b1;
        fs_data = 64'h1;
        ds_allow_in = 1'b1;
        flush = 1'b0;

        // Reset held with valid traffic presented
        repeat (3) @(negedge clk);
        chk("rst_ds_valid", {63'd0, ds_valid}, 64'd0);
        chk("rst_allow_in", {63'd0, fs_ds_reg_allow_in}, 64'd1);
        chk("rst_occupancy", {62'd0, occupancy}, 64'd0);
        chk("rst_ds_data", ds_data, 64'd0);
        fs_to_ds_reg_valid = 1'b0;
        reset = 1'b1;

        step(1'b1, 64'hA000_0000_0000_0000, 1'b1, 1'b0);
        chk("first_push_data", ds_data, 64'hA000_0000_0000_0000);
        chk("first_push_valid", {63'd0, ds_valid}, 64'd1);

        // Streaming
        for (int i = 0; i < 4; i++) begin
            step(1'b1, mk(32'(i * 4)), 1'b1, 1'b0);
            chk("stream_pc", {32'd0, ds_data[31:0]}, 64'(i * 4));
            chk("stream_occ", {62'd0, occupancy}, 64'd1);
            chk("stream_allow", {63'd0, fs_ds_reg_allow_in}, 64'd1);
        end
        step(1'b0, 64'd0, 1'b1, 1'b0);
        chk("drain_empty", {63'd0, ds_valid}, 64'd0);

        // Stall / skid
        step(1'b1, mk(32'h10), 1'b0, 1'b0);
        step(1'b1, mk(32'h14), 1'b0, 1'b0);
        chk("skid_occ", {62'd0, occupancy}, 64'd2);
        chk("skid_allow", {63'd0, fs_ds_reg_allow_in}, 64'd0);
        step(1'b1, mk(32'h18), 1'b0, 1'b0);
        chk("skid_hold", {32'd0, ds_data[31:0]}, 64'h10);
        step(1'b1, mk(32'h18), 1'b1, 1'b0);
        chk("release_1", {32'd0, ds_data[31:0]}, 64'h14);
        step(1'b1, mk(32'h18), 1'b1, 1'b0);
        chk("release_2", {32'd0, ds_data[31:0]}, 64'h18);
        step(1'b0, 64'd0, 1'b1, 1'b0);
        chk("release_empty", {62'd0, occupancy}, 64'd0);

        // Flush while full, then flush with an accepted push pending
        step(1'b1, mk(32'h20), 1'b0, 1'b0);
        step(1'b1, mk(32'h24), 1'b0, 1'b0);
        step(1'b1, mk(32'h28), 1'b0, 1'b1);
        chk("flush_valid", {63'd0, ds_valid}, 64'd0);
        chk("flush_occ", {62'd0, occupancy}, 64'd0);
        chk("flush_allow", {63'd0, fs_ds_reg_allow_in}, 64'd1);
        step(1'b1, mk(32'h30), 1'b0, 1'b0);
        step(1'b1, mk(32'h34), 1'b0, 1'b1);
        chk("flush_drop_push", {62'd0, occupancy}, 64'd0);
        step(1'b1, mk(32'h80), 1'b0, 1'b0);
        chk("after_flush_pc", {32'd0, ds_data[31:0]}, 64'h80);

        // Async reset between edges while full
        step(1'b1, mk(32'h84), 1'b0, 1'b0);
        chk("pre_areset_occ", {62'd0, occupancy}, 64'd2);
        fs_to_ds_reg_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("areset_valid", {63'd0, ds_valid}, 64'd0);
        chk("areset_allow", {63'd0, fs_ds_reg_allow_in}, 64'd1);
        chk("areset_occ", {62'd0, occupancy}, 64'd0);
        q.delete();
        m_allow = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, mk(32'h90), 1'b1, 1'b0);
        chk("post_areset_pc", {32'd0, ds_data[31:0]}, 64'h90);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99, 0) < 70) ? 1'b1 : 1'b0,
                 {$urandom, $urandom},
                 ($urandom_range(99, 0) < 55) ? 1'b1 : 1'b0,
                 ($urandom_range(99, 0) < 5) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
